// File: rtl/rsbrctl01a_pkg.sv
// Shared definitions for the bit-rate change controller and the baud generator.
// Holds the rate codes (including the generator's reset rate), the controller
// state encoding and the rate-code validity check.
package rsbrctl01a_pkg;

  localparam logic [3:0] RATE_1     = 4'h1;
  localparam logic [3:0] RATE_2     = 4'h2;
  localparam logic [3:0] RATE_3     = 4'h3;
  localparam logic [3:0] RATE_4     = 4'h4;
  localparam logic [3:0] RATE_5     = 4'h5;
  localparam logic [3:0] RATE_6     = 4'h6;
  localparam logic [3:0] RATE_7     = 4'h7;
  localparam logic [3:0] RATE_8     = 4'h8;
  localparam logic [3:0] RATE_9     = 4'h9;
  localparam logic [3:0] RATE_A     = 4'hA;
  localparam logic [3:0] RATE_F     = 4'hF;
  // Rate the baud generator comes out of reset with.
  localparam logic [3:0] RATE_RESET = RATE_3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Codes 1..A and F are usable; 0 and B..E are not.
  function automatic logic RateValid(input logic [3:0] code);
    RateValid = ((code >= RATE_1) && (code <= RATE_A)) || (code == RATE_F);
  endfunction

endpackage

// File: rtl/rsbrctl01a.sv
// Bit-rate change controller.
// Accepts a rate-change request, holds the TX/RX engines, waits for them to go
// idle (bounded by DRAIN_TIMEOUT), drives the new BitRateSel and then waits
// SETTLE_CYCLES for the baud generator to re-lock before pulsing Done.
// Ports:
//   F50Clk      clock (50 MHz)
//   reset_n     asynchronous active-low reset
//   ReqValid    one-cycle request strobe, honoured only when idle
//   ReqRate     requested rate code, sampled with ReqValid
//   TxBusy      transmitter mid-frame
//   RxBusy      receiver mid-frame
//   BitRateSel  registered rate code to the baud generator
//   Hold        engines must not start a new frame (DRAIN/SETTLE)
//   Busy        controller not idle
//   Done        one-cycle completion pulse
//   Err         request rejected or aborted, meaningful with Done
module rsbrctl01a
  import rsbrctl01a_pkg::*;
#(
  parameter logic [15:0] SETTLE_CYCLES = 16'd53602,
  parameter logic [23:0] DRAIN_TIMEOUT = 24'd5000000
) (
  input  logic       F50Clk,
  input  logic       reset_n,
  input  logic       ReqValid,
  input  logic [3:0] ReqRate,
  input  logic       TxBusy,
  input  logic       RxBusy,
  output logic [3:0] BitRateSel,
  output logic       Hold,
  output logic       Busy,
  output logic       Done,
  output logic       Err
);

  state_e      state_q,      state_d;
  logic [3:0]  rate_q,       rate_d;
  logic [3:0]  sel_q,        sel_d;
  logic [15:0] settle_cnt_q, settle_cnt_d;
  logic [23:0] drain_cnt_q,  drain_cnt_d;
  logic        hold_q,       hold_d;
  logic        busy_q,       busy_d;
  logic        done_q,       done_d;
  logic        err_q,        err_d;

  always_ff @(posedge F50Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      rate_q       <= RATE_RESET;
      sel_q        <= RATE_RESET;
      settle_cnt_q <= 16'd0;
      drain_cnt_q  <= 24'd0;
      hold_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rate_q       <= rate_d;
      sel_q        <= sel_d;
      settle_cnt_q <= settle_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      hold_q       <= hold_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rate_d       = rate_q;
    sel_d        = sel_q;
    settle_cnt_d = settle_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    err_d        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (ReqValid) begin
          if (!RateValid(ReqRate)) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end else if (ReqRate == sel_q) begin
            // Already at the requested rate: complete without holding the engines.
            state_d = ST_DONE;
          end else begin
            rate_d      = ReqRate;
            drain_cnt_d = 24'd0;
            state_d     = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Idle wins over the timeout when both happen in the same cycle.
        if (!TxBusy && !RxBusy) begin
          sel_d        = rate_q;
          settle_cnt_d = 16'd0;
          state_d      = ST_SETTLE;
        end else if (drain_cnt_q == (DRAIN_TIMEOUT - 24'd1)) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else if (drain_cnt_q != 24'hFF_FFFF) begin
          drain_cnt_d = drain_cnt_q + 24'd1;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt_q == (SETTLE_CYCLES - 16'd1)) begin
          state_d = ST_DONE;
        end else begin
          settle_cnt_d = settle_cnt_q + 16'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Flags are decoded from the next state so they come straight off flops.
    hold_d = (state_d == ST_DRAIN) || (state_d == ST_SETTLE);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  assign BitRateSel = sel_q;
  assign Hold       = hold_q;
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign Err        = err_q;

endmodule

// File: tb/tb_rsbrctl01a.sv
// Testbench for rsbrctl01a: the whole stimulus is generated up front, the
// expected output trace is derived from it transaction by transaction, then
// the stimulus is replayed against the DUT and every cycle is compared.
// A final directed sequence exercises reset in the middle of SETTLE.
module tb_rsbrctl01a;

  localparam int S  = 20;
  localparam int T  = 100;
  localparam int L  = 3000;
  localparam int LX = L + S + T + 20;

  logic       F50Clk = 1'b0;
  logic       reset_n;
  logic       ReqValid;
  logic [3:0] ReqRate;
  logic       TxBusy;
  logic       RxBusy;
  logic [3:0] BitRateSel;
  logic       Hold;
  logic       Busy;
  logic       Done;
  logic       Err;

  rsbrctl01a #(
    .SETTLE_CYCLES(16'd20),
    .DRAIN_TIMEOUT(24'd100)
  ) dut (
    .F50Clk    (F50Clk),
    .reset_n   (reset_n),
    .ReqValid  (ReqValid),
    .ReqRate   (ReqRate),
    .TxBusy    (TxBusy),
    .RxBusy    (RxBusy),
    .BitRateSel(BitRateSel),
    .Hold      (Hold),
    .Busy      (Busy),
    .Done      (Done),
    .Err       (Err)
  );

  always #5 F50Clk = ~F50Clk;

  // Stimulus per cycle and the expected outputs per cycle.
  logic       req_a [LX];
  logic [3:0] rate_a[LX];
  logic       tx_a  [LX];
  logic       rx_a  [LX];
  logic [3:0] e_sel [LX];
  logic       e_hold[LX];
  logic       e_busy[LX];
  logic       e_done[LX];
  logic       e_err [LX];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] obs();
    return {24'd0, BitRateSel, Hold, Busy, Done, Err};
  endfunction

  function automatic bit rate_ok(input logic [3:0] r);
    return ((r >= 4'd1) && (r <= 4'd10)) || (r == 4'd15);
  endfunction

  task automatic build_stimulus();
    bit tx, rx;
    for (int k = 0; k < LX; k++) begin
      req_a[k] = 1'b0; rate_a[k] = 4'h0; tx_a[k] = 1'b0; rx_a[k] = 1'b0;
    end
    // Directed part
    req_a[5]   = 1'b1; rate_a[5]   = 4'hB;  // invalid code
    req_a[10]  = 1'b1; rate_a[10]  = 4'h3;  // same as current
    req_a[20]  = 1'b1; rate_a[20]  = 4'h7;  // normal change, engines idle
    req_a[60]  = 1'b1; rate_a[60]  = 4'hF;  // waits for TxBusy
    for (int k = 61; k <= 109; k++) tx_a[k] = 1'b1;
    req_a[140] = 1'b1; rate_a[140] = 4'h9;  // RxBusy stuck -> timeout
    for (int k = 141; k <= 349; k++) rx_a[k] = 1'b1;
    req_a[250] = 1'b1; rate_a[250] = 4'h2;  // idle arrives on the last allowed cycle
    req_a[380] = 1'b1; rate_a[380] = 4'h9;  // change to 9 ...
    req_a[385] = 1'b1; rate_a[385] = 4'hB;  // ... requests while busy are ignored
    req_a[390] = 1'b1; rate_a[390] = 4'h1;
    // Random part
    tx = 1'b0; rx = 1'b0;
    for (int k = 410; k < LX; k++) begin
      if (tx) tx = ($urandom_range(0, 39) != 0);
      else    tx = ($urandom_range(0, 5) == 0);
      if (rx) rx = ($urandom_range(0, 149) != 0);
      else    rx = ($urandom_range(0, 9) == 0);
      tx_a[k] = tx;
      rx_a[k] = rx;
      if (k < L - 5) begin
        req_a[k]  = ($urandom_range(0, 24) == 0);
        rate_a[k] = 4'($urandom_range(0, 15));
      end
    end
  endtask

  // Walk the request stream: each honoured request produces a known
  // window of Hold/Busy, a completion cycle and possibly a new rate.
  task automatic build_expect();
    int free;
    logic [3:0] cur;
    free = 0;
    cur  = 4'h3;
    for (int k = 0; k < LX; k++) begin
      e_sel[k] = 4'h3; e_hold[k] = 1'b0; e_busy[k] = 1'b0; e_done[k] = 1'b0; e_err[k] = 1'b0;
    end
    for (int c = 0; c < L; c++) begin
      if (c >= free && req_a[c]) begin
        if (!rate_ok(rate_a[c]) || rate_a[c] == cur) begin
          e_busy[c+1] = 1'b1;
          e_done[c+1] = 1'b1;
          e_err[c+1]  = !rate_ok(rate_a[c]);
          free = c + 2;
        end else begin
          int d;
          d = -1;
          for (int k = c + 1; k <= c + T; k++)
            if (d < 0 && !tx_a[k] && !rx_a[k]) d = k;
          if (d >= 0) begin
            for (int k = c + 1; k <= d + S; k++) begin
              e_hold[k] = 1'b1; e_busy[k] = 1'b1;
            end
            e_busy[d+S+1] = 1'b1;
            e_done[d+S+1] = 1'b1;
            cur = rate_a[c];
            for (int k = d + 1; k < LX; k++) e_sel[k] = cur;
            free = d + S + 2;
          end else begin
            for (int k = c + 1; k <= c + T; k++) begin
              e_hold[k] = 1'b1; e_busy[k] = 1'b1;
            end
            e_busy[c+T+1] = 1'b1;
            e_done[c+T+1] = 1'b1;
            e_err[c+T+1]  = 1'b1;
            free = c + T + 2;
          end
        end
      end
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    ReqValid = 1'b0;
    ReqRate  = 4'h0;
    TxBusy   = 1'b0;
    RxBusy   = 1'b0;
    build_stimulus();
    build_expect();

    repeat (3) @(posedge F50Clk);
    #1;
    chk("in_reset", obs(), {24'd0, 4'h3, 4'b0000});
    #2 reset_n = 1'b1;

    for (int c = 0; c < L; c++) begin
      @(posedge F50Clk);
      #1;
      chk($sformatf("cyc%0d", c), obs(),
          {24'd0, e_sel[c], e_hold[c], e_busy[c], e_done[c], e_err[c]});
      ReqValid = req_a[c];
      ReqRate  = rate_a[c];
      TxBusy   = tx_a[c];
      RxBusy   = rx_a[c];
    end

    // Reset in the middle of SETTLE.
    ReqValid = 1'b0;
    TxBusy   = 1'b0;
    RxBusy   = 1'b0;
    @(posedge F50Clk);
    #2 reset_n = 1'b0;
    #1 chk("rst_async", obs(), {24'd0, 4'h3, 4'b0000});
    @(posedge F50Clk);
    #2 reset_n = 1'b1;
    @(posedge F50Clk);
    #1;
    ReqValid = 1'b1;
    ReqRate  = 4'h5;
    @(posedge F50Clk);
    #1;
    ReqValid = 1'b0;
    chk("rst_seq_hold", obs(), {24'd0, 4'h3, 4'b1100});
    repeat (4) @(posedge F50Clk);
    #1;
    chk("rst_seq_settle", obs(), {24'd0, 4'h5, 4'b1100});
    #2 reset_n = 1'b0;
    #1 chk("rst_mid_settle", obs(), {24'd0, 4'h3, 4'b0000});
    #2 reset_n = 1'b1;
    for (int k = 0; k < S + 10; k++) begin
      @(posedge F50Clk);
      #1;
      chk($sformatf("post_rst%0d", k), obs(), {24'd0, 4'h3, 4'b0000});
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
